srt_div_ctrl: RTL and testbench

Sequencer for the radix-4 SRT divide step in the M-extension unit. It accepts DIV/DIVU/REM/REMU requests from the execute stage and takes operand absolute values. It normalizes the divisor and steps the combinational quotient-select/carry-save step once per cycle for a shift-dependent count. It then resolves the redundant remainder and quotient, applies sign and zero-divisor rules, and returns one 32-bit result through a valid pulse.

---
 rtl/div_pkg.sv | 30 +++
 rtl/lzc32.sv | 15 +
 rtl/srt_step.sv | 63 ++++++
 rtl/srt_div_ctrl.sv | 170 +++++++++++++++++
 tb/tb_srt_div_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the radix-4 SRT divider sequencer: widths, op codes,
// state encoding and the iteration-count rule.
package div_pkg;

  localparam int unsigned REM_W = 66;
  localparam int unsigned DIV_W = 34;
  localparam int unsigned Q_W   = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ITER,
    S_CORR,
    S_FIX,
    S_DONE
  } state_t;

  // Radix-4 steps needed for a divisor shifted left by s: ceil((s+2)/2).
  function automatic logic [4:0] iter_count(input logic [4:0] s);
    logic [5:0] t;
    t = {1'b0, s} + (s[0] ? 6'd3 : 6'd2);
    return t[5:1];
  endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; result is don't-care for zero input.
module lzc32 (
  input  logic [31:0] value,
  output logic [4:0]  count
);

  // Highest set bit wins since it is visited last.
  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 5'(31 - i);
    end
  end

endmodule

// File: rtl/srt_step.sv
// One radix-4 SRT step: R <- 4R - q*D with q in {-2..2}, carry-save remainder,
// quotient digits appended to the positive/negative digit vectors.
module srt_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0] sum,
  input  logic [REM_W-1:0] carry,
  input  logic [DIV_W-1:0] d,
  input  logic [DIV_W-1:0] d_neg,
  input  logic [Q_W-1:0]   pos_q,
  input  logic [Q_W-1:0]   neg_q,
  output logic [REM_W-1:0] next_sum,
  output logic [REM_W-1:0] next_carry,
  output logic [Q_W-1:0]   next_pos_q,
  output logic [Q_W-1:0]   next_neg_q
);

  localparam int unsigned EST_W = REM_W + 4;

  logic [REM_W-1:0]        rem;
  logic signed [EST_W-1:0] x8;
  logic signed [EST_W-1:0] d1;
  logic signed [EST_W-1:0] d3;
  logic [1:0]              pd;
  logic [1:0]              nd;
  logic [REM_W-1:0]        term;
  logic [REM_W-1:0]        a;
  logic [REM_W-1:0]        b;

  // Digit selection compares 8R against D' and 3D' (D' = D aligned to the top).
  always_comb begin
    rem  = sum + carry;
    x8   = {rem[REM_W-1], rem, 3'b000};
    d1   = EST_W'({d, 32'b0});
    d3   = d1 + (d1 <<< 1);
    pd   = 2'd0;
    nd   = 2'd0;
    term = '0;
    if (x8 >= d3) begin
      pd   = 2'd2;
      term = REM_W'({d_neg, 32'b0} << 1);
    end else if (x8 >= d1) begin
      pd   = 2'd1;
      term = {d_neg, 32'b0};
    end else if (x8 > -d1) begin
      term = '0;
    end else if (x8 > -d3) begin
      nd   = 2'd1;
      term = {d, 32'b0};
    end else begin
      nd   = 2'd2;
      term = REM_W'({d, 32'b0} << 1);
    end

    a          = sum << 2;
    b          = carry << 2;
    next_sum   = a ^ b ^ term;
    next_carry = ((a & b) | (a & term) | (b & term)) << 1;
    next_pos_q = (pos_q << 2) | Q_W'(pd);
    next_neg_q = (neg_q << 2) | Q_W'(nd);
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// Radix-4 SRT divide sequencer for DIV/DIVU/REM/REMU: normalize, iterate,
// resolve the redundant remainder/quotient, apply signs, return one result.
module srt_div_ctrl
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic             sa_q;
  logic             sb_q;
  logic [Q_W-1:0]   a_abs_q;
  logic [Q_W-1:0]   b_abs_q;
  logic [4:0]       s_q;
  logic [4:0]       cnt_q;
  logic [DIV_W-1:0] d_q;
  logic [DIV_W-1:0] d_neg_q;
  logic [REM_W-1:0] sum_q;
  logic [REM_W-1:0] carry_q;
  logic [Q_W-1:0]   pos_q_q;
  logic [Q_W-1:0]   neg_q_q;

  logic             op_signed;
  logic             is_rem;
  logic             b_zero;
  logic [4:0]       lz;
  logic [Q_W-1:0]   dn;
  logic [REM_W-1:0] step_sum;
  logic [REM_W-1:0] step_carry;
  logic [Q_W-1:0]   step_pos_q;
  logic [Q_W-1:0]   step_neg_q;
  logic [REM_W-1:0] r_sum;
  logic [REM_W-1:0] r_corr;
  logic [Q_W-1:0]   q_raw;
  logic [Q_W-1:0]   q_corr;
  logic [6:0]       rem_shift;
  logic [Q_W-1:0]   rem_mag;
  logic [Q_W-1:0]   fix_result;
  logic [Q_W-1:0]   zero_result;

  lzc32 u_lzc (
    .value (b_abs_q),
    .count (lz)
  );

  srt_step u_step (
    .sum        (sum_q),
    .carry      (carry_q),
    .d          (d_q),
    .d_neg      (d_neg_q),
    .pos_q      (pos_q_q),
    .neg_q      (neg_q_q),
    .next_sum   (step_sum),
    .next_carry (step_carry),
    .next_pos_q (step_pos_q),
    .next_neg_q (step_neg_q)
  );

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_NORM;
      S_NORM:  state_d = b_zero ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == 5'd1) state_d = S_CORR;
      S_CORR:  state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != S_IDLE);
      valid_o <= (state_d == S_DONE);
    end
  end

  // Normalization, final correction and sign fix-up.
  always_comb begin
    op_signed   = (op_i == OP_DIV) || (op_i == OP_REM);
    is_rem      = (op_q == OP_REM) || (op_q == OP_REMU);
    b_zero      = (b_abs_q == '0);
    dn          = b_abs_q << lz;
    r_sum       = sum_q + carry_q;
    q_raw       = pos_q_q - neg_q_q;
    r_corr      = r_sum[REM_W-1] ? r_sum + {d_q, 32'b0} : r_sum;
    q_corr      = r_sum[REM_W-1] ? q_raw - 32'd1 : q_raw;
    rem_shift   = 7'd32 + 7'(s_q);
    rem_mag     = Q_W'(sum_q >> rem_shift);
    fix_result  = is_rem ? (sa_q ? -rem_mag : rem_mag)
                         : ((sa_q ^ sb_q) ? -pos_q_q : pos_q_q);
    zero_result = is_rem ? (sa_q ? -a_abs_q : a_abs_q) : 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_abs_q  <= '0;
      b_abs_q  <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      d_q      <= '0;
      d_neg_q  <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      pos_q_q  <= '0;
      neg_q_q  <= '0;
      result_o <= '0;
    end else if (!flush_i) begin
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q    <= op_i;
          sa_q    <= op_signed & dividend_i[31];
          sb_q    <= op_signed & divisor_i[31];
          a_abs_q <= (op_signed & dividend_i[31]) ? -dividend_i : dividend_i;
          b_abs_q <= (op_signed & divisor_i[31]) ? -divisor_i : divisor_i;
        end
        S_NORM: begin
          if (b_zero) begin
            result_o <= zero_result;
          end else begin
            s_q     <= lz;
            d_q     <= {2'b00, dn};
            d_neg_q <= -{2'b00, dn};
            sum_q   <= lz[0] ? {5'b0, a_abs_q, 29'b0} : {4'b0, a_abs_q, 30'b0};
            carry_q <= '0;
            pos_q_q <= '0;
            neg_q_q <= '0;
            cnt_q   <= iter_count(lz);
          end
        end
        S_ITER: begin
          sum_q   <= step_sum;
          carry_q <= step_carry;
          pos_q_q <= step_pos_q;
          neg_q_q <= step_neg_q;
          cnt_q   <= cnt_q - 5'd1;
        end
        S_CORR: begin
          sum_q   <= r_corr;
          pos_q_q <= q_corr;
        end
        S_FIX:   result_o <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Self-checking bench for srt_div_ctrl: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_srt_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp = 32'd0;

  srt_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Architectural result: RISC-V M-extension divide semantics.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle of valid_o: 2 for a zero divisor, else ceil((s+2)/2) + 4.
  function automatic int model_latency(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int s;
    m = (!op[0] && b[31]) ? (32'd0 - b) : b;
    if (m == 0) return 2;
    s = 0;
    while (!m[31]) begin
      m = m << 1;
      s++;
    end
    return (s + 3) / 2 + 4;
  endfunction

  // Issue one request; optionally pulse a second start in cycle 3 that must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    int cyc;
    logic [31:0] exp;
    exp = model_result(op, a, b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    check({tag, ".busy1"}, 32'(busy_o), 32'd1);
    while (!valid_o && cyc < 40) begin
      if (poke && cyc == 3) begin
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check({tag, ".lat"}, 32'(cyc), 32'(model_latency(op, b)));
    check({tag, ".res"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(valid_o), 32'd0);
    check({tag, ".idle"}, 32'(busy_o), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int vcnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.result", result_o, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1'b0);
    run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_min", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("remu_min", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("busy_start", 2'b01, 32'd100, 32'd7, 1'b1);

    // Flush in cycle 6 of DIVU 100/7: back to IDLE, no pulse, result held.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush.idle", 32'(busy_o), 32'd0);
    vcnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (valid_o) vcnt++;
    end
    check("flush.novalid", 32'(vcnt), 32'd0);
    check("flush.held", result_o, last_exp);

    // Start and flush in the same IDLE cycle: start is dropped.
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("sflush.idle", 32'(busy_o), 32'd0);
    vcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid_o) vcnt++;
    end
    check("sflush.novalid", 32'(vcnt), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        3:       rb = $urandom >> $urandom_range(0, 31);
        4:       rb = 32'hFFFF_FFFF;
        default: rb = 32'h8000_0000;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
